// File: rtl/dmem_pkg.sv
// Shared constants for the multi-cycle data-memory responder:
// FSM state encoding, wait-state counter width and default sizing.
package dmem_pkg;

   // FSM state encoding
   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_WAIT = 2'd1;
   localparam logic [1:0] S_ACK  = 2'd2;

   // Wait-state counter width; covers WAIT_CYCLES up to 15
   localparam int CNT_W = 4;

   // Default sizing
   localparam int DEF_ADDR_WORDS  = 64;
   localparam int DEF_WAIT_CYCLES = 2;

endpackage

// File: rtl/dmem_array.sv
// Word storage for the data-memory responder: one synchronous write
// port and two asynchronous read ports (functional read and debug read).
module dmem_array #(
   parameter int WORDS = 64,
   parameter int AW    = 6
) (
   input  logic          clk,
   input  logic          we,
   input  logic [AW-1:0] waddr,
   input  logic [31:0]   wdata,
   input  logic [AW-1:0] raddr,
   output logic [31:0]   rdata,
   input  logic [AW-1:0] dbaddr,
   output logic [31:0]   dbdata
);

   logic [31:0] mem [WORDS];

   // Word write on the clock edge; contents are never cleared by reset
   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
   end

   assign rdata  = mem[raddr];
   assign dbdata = mem[dbaddr];

endmodule

// File: rtl/dmem_responder.sv
// Multi-cycle data-memory target: captures a req/ack request, counts a
// fixed number of wait states, performs the word read or write and
// returns a one-cycle registered ack with read data or an error flag.
module dmem_responder
   import dmem_pkg::*;
#(
   parameter int ADDR_WORDS  = DEF_ADDR_WORDS,
   parameter int WAIT_CYCLES = DEF_WAIT_CYCLES
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          req,
   input  logic [31:0]                   A,
   input  logic [31:0]                   WD,
   input  logic                          WE,
   output logic [31:0]                   RD,
   output logic                          ack,
   output logic                          err,
   output logic                          busy,
   input  logic [$clog2(ADDR_WORDS)-1:0] DBaddr,
   output logic [31:0]                   DBdata
);

   localparam int AW = $clog2(ADDR_WORDS);

   // Counter preload: WAIT stays for exactly WAIT_CYCLES cycles
   localparam int              LOAD_I   = (WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0;
   localparam logic [CNT_W-1:0] CNT_LOAD = LOAD_I[CNT_W-1:0];
   localparam logic [29:0]      WORDS_30 = ADDR_WORDS[29:0];

   logic [1:0]       state_reg, state_next;
   logic [CNT_W-1:0] cnt_reg, cnt_next;

   // Latched request (only the word index is needed once validated)
   logic [AW-1:0]    idx_reg;
   logic [31:0]      wd_reg;
   logic             we_reg;

   // Effective request: live inputs while IDLE (zero-wait case), latches otherwise
   logic [AW-1:0]    idx_eff;
   logic [31:0]      wd_eff;
   logic             we_eff;

   logic             req_bad;
   logic             fire;
   logic             ack_next, err_next, busy_next;
   logic [31:0]      rd_next;
   logic             mem_we;
   logic [31:0]      mem_rdata;

   logic [31:0]      rd_reg;
   logic             ack_reg, err_reg, busy_reg;

   assign req_bad = (A[1:0] != 2'b00) || (A[31:2] >= WORDS_30);

   // Select live or latched request fields for the array access
   always_comb begin
      idx_eff = idx_reg;
      wd_eff  = wd_reg;
      we_eff  = we_reg;
      if (state_reg == S_IDLE) begin
         idx_eff = A[AW+1:2];
         wd_eff  = WD;
         we_eff  = WE;
      end
   end

   // State and wait counter register
   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg <= S_IDLE;
         cnt_reg   <= '0;
      end else begin
         state_reg <= state_next;
         cnt_reg   <= cnt_next;
      end
   end

   // Next-state logic; fire marks a valid request entering ACK
   always_comb begin
      state_next = state_reg;
      cnt_next   = cnt_reg;
      fire       = 1'b0;
      case (state_reg)
         S_IDLE: begin
            if (req) begin
               if (req_bad) begin
                  state_next = S_ACK;
               end else if (WAIT_CYCLES == 0) begin
                  state_next = S_ACK;
                  fire       = 1'b1;
               end else begin
                  state_next = S_WAIT;
                  cnt_next   = CNT_LOAD;
               end
            end
         end
         S_WAIT: begin
            if (cnt_reg == '0) begin
               state_next = S_ACK;
               fire       = 1'b1;
            end else begin
               cnt_next = cnt_reg - 1'b1;
            end
         end
         S_ACK: begin
            state_next = S_IDLE;
         end
         default: begin
            state_next = S_IDLE;
            cnt_next   = '0;
         end
      endcase
   end

   // Output and array-strobe decode; writes are dropped when reset hits the commit edge
   always_comb begin
      ack_next  = (state_next == S_ACK);
      err_next  = (state_reg == S_IDLE) && req && req_bad;
      busy_next = (state_next != S_IDLE);
      rd_next   = (fire && !we_eff) ? mem_rdata : 32'd0;
      mem_we    = fire && we_eff && !reset;
   end

   // Request capture when a request is accepted in IDLE
   always_ff @(posedge clk) begin
      if (reset) begin
         idx_reg <= '0;
         wd_reg  <= '0;
         we_reg  <= 1'b0;
      end else if (state_reg == S_IDLE && req) begin
         idx_reg <= A[AW+1:2];
         wd_reg  <= WD;
         we_reg  <= WE;
      end
   end

   // Registered handshake outputs
   always_ff @(posedge clk) begin
      if (reset) begin
         ack_reg  <= 1'b0;
         err_reg  <= 1'b0;
         busy_reg <= 1'b0;
         rd_reg   <= '0;
      end else begin
         ack_reg  <= ack_next;
         err_reg  <= err_next;
         busy_reg <= busy_next;
         rd_reg   <= rd_next;
      end
   end

   assign ack  = ack_reg;
   assign err  = err_reg;
   assign busy = busy_reg;
   assign RD   = rd_reg;

   dmem_array #(
      .WORDS (ADDR_WORDS),
      .AW    (AW)
   ) u_array (
      .clk    (clk),
      .we     (mem_we),
      .waddr  (idx_eff),
      .wdata  (wd_eff),
      .raddr  (idx_eff),
      .rdata  (mem_rdata),
      .dbaddr (DBaddr),
      .dbdata (DBdata)
   );

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: a scoreboard queue receives the
// expected response when each request is driven; a monitor pops and
// compares on every ack.
module tb_dmem_responder;

   localparam int WORDS = 64;
   localparam int WAITC = 2;

   typedef struct packed {
      logic [31:0] rd;
      logic        err;
   } exp_t;

   logic        clk = 1'b0;
   logic        reset;
   logic        req;
   logic [31:0] A;
   logic [31:0] WD;
   logic        WE;
   logic [31:0] RD;
   logic        ack;
   logic        err;
   logic        busy;
   logic [5:0]  DBaddr;
   logic [31:0] DBdata;

   exp_t        sb_q[$];
   logic [31:0] model [WORDS];
   int          n_checks = 0;
   int          n_errors = 0;
   int          cyc = 0;

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   dmem_responder #(
      .ADDR_WORDS  (WORDS),
      .WAIT_CYCLES (WAITC)
   ) dut (
      .clk    (clk),
      .reset  (reset),
      .req    (req),
      .A      (A),
      .WD     (WD),
      .WE     (WE),
      .RD     (RD),
      .ack    (ack),
      .err    (err),
      .busy   (busy),
      .DBaddr (DBaddr),
      .DBdata (DBdata)
   );

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   // Scoreboard monitor: every ack must match the oldest pending expectation
   always @(posedge clk) begin
      exp_t e;
      #1;
      if (ack) begin
         if (sb_q.size() == 0) begin
            check_eq("spurious_ack", 32'd1, 32'd0);
         end else begin
            e = sb_q.pop_front();
            check_eq("ack_rd", RD, e.rd);
            check_eq("ack_err", {31'd0, err}, {31'd0, e.err});
            $display("txn cyc=%0d RD=0x%08h err=%0b (exp RD=0x%08h err=%0b)",
                     cyc, RD, err, e.rd, e.err);
         end
      end
   end

   function automatic exp_t expect_for(input logic we_i, input logic [31:0] a_i, input logic [31:0] wd_i);
      exp_t e;
      if (a_i[1:0] != 2'b00 || a_i[31:2] >= WORDS) begin
         e.rd = 32'd0; e.err = 1'b1;
      end else if (we_i) begin
         model[a_i[7:2]] = wd_i;
         e.rd = 32'd0; e.err = 1'b0;
      end else begin
         e.rd = model[a_i[7:2]]; e.err = 1'b0;
      end
      return e;
   endfunction

   // One request from IDLE; optionally changes A/WD after the capture edge
   task automatic do_txn(input logic we_i, input logic [31:0] a_i, input logic [31:0] wd_i,
                         input bit chg, input logic [31:0] a2, input logic [31:0] wd2);
      int n;
      bit bad;
      bad = (a_i[1:0] != 2'b00) || (a_i[31:2] >= WORDS);
      sb_q.push_back(expect_for(we_i, a_i, wd_i));
      req = 1'b1; WE = we_i; A = a_i; WD = wd_i;
      n = 0;
      do begin
         @(posedge clk); #1;
         n++;
         if (n == 1 && !bad) check_eq("busy_in_wait", {31'd0, busy}, 32'd1);
         if (chg && n == 1) begin
            A = a2; WD = wd2;
         end
      end while (!ack && n < 40);
      check_eq("latency", n, bad ? 32'd1 : 32'(WAITC + 1));
      req = 1'b0;
      @(posedge clk); #1;
   endtask

   initial begin
      int n;
      int last;
      logic [31:0] a_i, wd_i;

      reset = 1'b1; req = 1'b0; WE = 1'b0; A = '0; WD = '0; DBaddr = '0;

      // 1: reset then idle
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
      for (int i = 0; i < 10; i++) begin
         @(posedge clk); #1;
         check_eq("idle_ack",  {31'd0, ack},  32'd0);
         check_eq("idle_err",  {31'd0, err},  32'd0);
         check_eq("idle_busy", {31'd0, busy}, 32'd0);
         check_eq("idle_rd",   RD,            32'd0);
      end

      // Fill every word so later sweeps compare against known contents
      for (int i = 0; i < WORDS; i++) begin
         do_txn(1'b1, 32'(i * 4), 32'h5A000000 ^ (32'(i) * 32'h01010101), 1'b0, 0, 0);
      end

      // 2: write/read round trip and debug port visibility
      do_txn(1'b1, 32'h10, 32'hDEADBEEF, 1'b0, 0, 0);
      DBaddr = 6'd4; #1;
      check_eq("db_word4", DBdata, 32'hDEADBEEF);
      do_txn(1'b0, 32'h10, 32'h0, 1'b0, 0, 0);
      do_txn(1'b0, 32'h0C, 32'h0, 1'b0, 0, 0);

      // 3: misaligned read and out-of-range write are rejected without side effects
      do_txn(1'b0, 32'h12, 32'h0, 1'b0, 0, 0);
      do_txn(1'b1, 32'h100, 32'h1234, 1'b0, 0, 0);
      do_txn(1'b1, 32'h23, 32'hFFFFFFFF, 1'b0, 0, 0);
      for (int i = 0; i < WORDS; i++) begin
         DBaddr = 6'(i); #1;
         check_eq($sformatf("sweep_w%0d", i), DBdata, model[i]);
      end

      // 4: A/WD changes during WAIT are ignored
      do_txn(1'b1, 32'h20, 32'h11111111, 1'b1, 32'h24, 32'h22222222);
      DBaddr = 6'd8; #1;
      check_eq("chg_word8", DBdata, 32'h11111111);
      DBaddr = 6'd9; #1;
      check_eq("chg_word9", DBdata, model[9]);

      // 5: req held high across three writes; next request presented during ACK
      last = 0;
      req = 1'b1; WE = 1'b1;
      for (int i = 0; i < 3; i++) begin
         a_i  = 32'h40 + 32'(i * 4);
         wd_i = 32'hB0B00000 + 32'(i);
         sb_q.push_back(expect_for(1'b1, a_i, wd_i));
         A = a_i; WD = wd_i;
         n = 0;
         do begin
            @(posedge clk); #1;
            n++;
         end while (!ack && n < 40);
         check_eq("b2b_ack_seen", {31'd0, ack}, 32'd1);
         if (i > 0) check_eq("b2b_spacing", 32'(cyc - last), 32'(WAITC + 2));
         last = cyc;
      end
      req = 1'b0;
      @(posedge clk); #1;
      for (int i = 16; i < 19; i++) begin
         DBaddr = 6'(i); #1;
         check_eq($sformatf("b2b_w%0d", i), DBdata, model[i]);
      end

      // 6: reset on the commit edge of a write aborts it
      req = 1'b1; WE = 1'b1; A = 32'h30; WD = 32'hCAFEF00D;
      @(posedge clk); #1;
      check_eq("rst_busy_wait", {31'd0, busy}, 32'd1);
      @(posedge clk); #1;
      reset = 1'b1; req = 1'b0;
      @(posedge clk); #1;
      reset = 1'b0;
      check_eq("rst_busy", {31'd0, busy}, 32'd0);
      check_eq("rst_ack",  {31'd0, ack},  32'd0);
      repeat (5) begin
         @(posedge clk); #1;
         check_eq("rst_no_ack", {31'd0, ack}, 32'd0);
      end
      DBaddr = 6'd12; #1;
      check_eq("rst_word12", DBdata, model[12]);

      // Service still works after the abort
      do_txn(1'b0, 32'h30, 32'h0, 1'b0, 0, 0);

      check_eq("sb_empty", 32'(sb_q.size()), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
Multi-cycle data-memory responder: the target end of the processor data-memory interface (address, write data, write enable) with a req/ack handshake and a fixed, parameterised wait-state count. It replaces the zero-latency data memory when the team moves to a multi-cycle or stalled datapath. The block latches each request, counts wait states, performs the word read or write, and returns a one-cycle ack with read data or an error flag. A combinational debug read port exposes the array contents to the bench.

Parameters:
ADDR_WORDS, 64, number of 32-bit words in the array; valid byte addresses are 0 .. 4*ADDR_WORDS-4.
WAIT_CYCLES, 2, wait states between request capture and ack; legal range is 0..15.

Ports:
clk  input  1  rising-edge clock
reset  input  1  synchronous, active-high reset
req  input  1  request valid; the initiator holds it, with A/WD/WE stable, until ack
A  input  32  byte address
WD  input  32  write data
WE  input  1  1 = write, 0 = read
RD  output  32  read data; valid in the ack cycle only
ack  output  1  one-cycle completion pulse
err  output  1  qualifies ack: the request was misaligned or out of range
busy  output  1  high whenever state is not IDLE
DBaddr  input  6  debug word index (clog2 of ADDR_WORDS)
DBdata  output  32  combinational read of array[DBaddr]

Behaviour:
- Reset (synchronous, active-high) values: state=IDLE, ack=0, err=0, RD=0, busy=0, counter=0. Array contents are not cleared.
- States are IDLE, WAIT and ACK. All outputs except DBdata are registered.
- IDLE, req=0: stay in IDLE.
- IDLE, req=1: latch A, WD and WE into internal registers.
  - If A[1:0]!=0 or A[31:2]>=ADDR_WORDS, go directly to ACK with err=1, RD=0 and no array write.
  - Else if WAIT_CYCLES==0, go to ACK.
  - Else load counter=WAIT_CYCLES-1 and go to WAIT.
- WAIT: if counter==0, go to ACK; otherwise decrement. Changes on A/WD/WE/req during WAIT are ignored; the latched values are used.
- Transition into ACK on a valid request:
  - Read: RD <= array[latched A[31:2]], err <= 0.
  - Write: array[latched A[31:2]] <= latched WD on that same edge; RD <= 0.
- ACK: ack=1 for exactly one cycle, then unconditionally return to IDLE. req seen during the ACK cycle is not sampled. RD and err return to 0 on leaving ACK.
- Latency: ack is asserted exactly WAIT_CYCLES+1 cycles after the edge that sampled req. Minimum spacing between transactions is WAIT_CYCLES+2 cycles.
- Reset mid-transaction (in WAIT or ACK): the transaction is aborted, a pending write is discarded, and the block is in IDLE the next cycle.
- Error ack latency is 1 cycle regardless of WAIT_CYCLES.
- DBdata is a pure combinational read. It reflects a write starting the cycle after the write edge.
- Addressing is word-only; there are no byte enables.

Decomposition:
- Shared package dmem_pkg holds:
  - state encoding constants S_IDLE=2'd0, S_WAIT=2'd1, S_ACK=2'd2;
  - counter width localparam CNT_W=4;
  - default ADDR_WORDS and WAIT_CYCLES.
- Sub-module dmem_array: ADDR_WORDS x 32 storage with a synchronous write port and two asynchronous read ports (the functional read and the debug read).
- The FSM, counter and request latches stay in dmem_responder.

Test Plan:
1. Reset then idle: hold reset 2 cycles, req=0 for 10 cycles -> ack=0, err=0, busy=0, RD=0 throughout.
2. Write/read round trip with WAIT_CYCLES=2: req, WE=1, A=0x10, WD=0xDEADBEEF at edge 0 -> ack at cycle 3 with err=0. Then read A=0x10 -> ack with RD=0xDEADBEEF; DBdata at DBaddr=4 shows 0xDEADBEEF after the write edge.
3. Errors: read A=0x12 -> ack one cycle later with err=1, RD=0. Write A=0x100 (word 64) with WD=0x1234 -> err=1, and a DBdata sweep shows no word changed.
4. Input changes during WAIT: write to A=0x20 with WD=0x11111111, then change A to 0x24 and WD to 0x22222222 during WAIT -> word 8=0x11111111, word 9 unchanged.
5. Back-to-back: req held high across 3 write requests -> acks spaced exactly 4 cycles apart; a request presented during ACK is serviced starting in the next IDLE cycle.
6. Reset mid-WAIT: write A=0x30 with WD=0xCAFEF00D, assert reset during WAIT -> no ack, word 12 retains its prior value, busy=0 after reset.
